// File: rtl/pc_unit_ras.sv
// Fetch-stage program counter with next-PC priority select and a circular
// return-address stack that predicts the targets of call/return pairs.
module pc_unit_ras #(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [PC_W-1:0] INC       = PC_W'(4),
  parameter int              RAS_DEPTH = 8
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         en,
  input  logic                         redirect_valid,
  input  logic [PC_W-1:0]              redirect_pc,
  input  logic                         jump_valid,
  input  logic [PC_W-1:0]              jump_pc,
  input  logic                         call,
  input  logic                         ret_valid,
  input  logic [PC_W-1:0]              ret_fallback_pc,
  output logic [PC_W-1:0]              pco,
  output logic [PC_W-1:0]              pc_next,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_empty,
  output logic                         ras_full,
  output logic                         ras_miss
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [PC_W-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]   wp;
  logic [PW-1:0]   top_idx;
  logic [PC_W-1:0] pc_inc;
  logic            push;
  logic            pop;
  logic            replace;
  logic            miss_d;
  logic            wr_en;
  logic [PW-1:0]   wr_idx;

  assign top_idx   = wp - PW'(1);
  assign pc_inc    = pco + INC;
  assign ras_empty = (ras_count == '0);
  assign ras_full  = (ras_count == CW'(RAS_DEPTH));

  // NOTE: every output of this block gets a default first so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    pc_next = pc_inc;
    push    = 1'b0;
    pop     = 1'b0;
    replace = 1'b0;
    miss_d  = 1'b0;
    if (redirect_valid) begin
      pc_next = redirect_pc;
    end else if (!en) begin
      pc_next = pco;
    end else if (ret_valid) begin
      if (!ras_empty) begin
        pc_next = ras_mem[top_idx];
        replace = jump_valid && call;
        pop     = !(jump_valid && call);
      end else begin
        pc_next = ret_fallback_pc;
        miss_d  = 1'b1;
        push    = jump_valid && call;
      end
    end else if (jump_valid) begin
      pc_next = jump_pc;
      push    = call;
    end
  end

  assign wr_en  = push || replace;
  assign wr_idx = replace ? top_idx : wp;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pco       <= RESET_PC;
      wp        <= '0;
      ras_count <= '0;
      ras_miss  <= 1'b0;
    end else begin
      pco      <= pc_next;
      ras_miss <= miss_d;
      if (push) begin
        wp <= wp + PW'(1);
        if (!ras_full) ras_count <= ras_count + CW'(1);
      end else if (pop) begin
        wp        <= wp - PW'(1);
        ras_count <= ras_count - CW'(1);
      end
    end
  end

  // NOTE: stack entries carry no reset; validity is tracked solely by
  // ras_count, so reset only needs to clear the count and pointer.
  always_ff @(posedge CLK) begin
    if (wr_en) ras_mem[wr_idx] <= pc_inc;
  end

endmodule

// File: tb/tb_pc_unit_ras.sv
// Scoreboard bench for pc_unit_ras: a queue-based return-stack model predicts
// each cycle's registered outputs; a monitor compares them after every edge.
module tb_pc_unit_ras;

  localparam int          PC_W  = 32;
  localparam int          DEPTH = 8;
  localparam logic [31:0] RPC   = 32'h100;

  typedef struct {
    logic [31:0] pco;
    int          count;
    logic        miss;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        en = 1'b0, redirect_valid = 1'b0, jump_valid = 1'b0;
  logic        call = 1'b0, ret_valid = 1'b0;
  logic [31:0] redirect_pc = '0, jump_pc = '0, ret_fallback_pc = '0;
  logic [31:0] pco, pc_next;
  logic [3:0]  ras_count;
  logic        ras_empty, ras_full, ras_miss;

  int checks = 0;
  int errors = 0;

  exp_t        sb [$];
  logic [31:0] m_stack [$];
  logic [31:0] m_pco = RPC;

  pc_unit_ras #(.PC_W(PC_W), .RESET_PC(RPC), .INC(32'd4), .RAS_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .en(en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .jump_valid(jump_valid), .jump_pc(jump_pc), .call(call),
    .ret_valid(ret_valid), .ret_fallback_pc(ret_fallback_pc),
    .pco(pco), .pc_next(pc_next), .ras_count(ras_count),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_miss(ras_miss)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Drive one cycle of inputs, predict the outcome, queue the expectation.
  task automatic step(input logic rst, input logic e, input logic rv, input logic [31:0] rpc,
                      input logic jv, input logic [31:0] jpc, input logic c,
                      input logic rt, input logic [31:0] fpc);
    logic [31:0] nxt, inc;
    logic        miss;
    exp_t        x;
    @(negedge CLK);
    RST = rst; en = e; redirect_valid = rv; redirect_pc = rpc;
    jump_valid = jv; jump_pc = jpc; call = c; ret_valid = rt; ret_fallback_pc = fpc;
    inc  = m_pco + 32'd4;
    miss = 1'b0;
    nxt  = inc;
    if (rv) nxt = rpc;
    else if (!e) nxt = m_pco;
    else if (rt) begin
      if (m_stack.size() > 0) begin
        nxt = m_stack[$];
        if (jv && c) m_stack[m_stack.size()-1] = inc;
        else void'(m_stack.pop_back());
      end else begin
        nxt  = fpc;
        miss = 1'b1;
        if (jv && c) m_stack.push_back(inc);
      end
    end else if (jv) begin
      nxt = jpc;
      if (c) m_stack.push_back(inc);
    end
    if (m_stack.size() > DEPTH) void'(m_stack.pop_front());
    #1;
    if (!rst) check("pc_next", pc_next, nxt);
    if (rst) begin
      m_stack.delete();
      nxt  = RPC;
      miss = 1'b0;
    end
    m_pco   = nxt;
    x.pco   = nxt;
    x.count = m_stack.size();
    x.miss  = miss;
    sb.push_back(x);
  endtask

  task automatic idle();
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic redir(input logic [31:0] a);
    step(0, 1, 1, a, 0, 0, 0, 0, 0);
  endtask
  task automatic do_call(input logic [31:0] tgt);
    step(0, 1, 0, 0, 1, tgt, 1, 0, 0);
  endtask
  task automatic do_ret(input logic [31:0] fpc);
    step(0, 1, 0, 0, 0, 0, 0, 1, fpc);
  endtask

  // Monitor: the DUT presents new registered state after every edge.
  always @(posedge CLK) begin
    #1;
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      check("pco", pco, x.pco);
      check("ras_count", 32'(ras_count), 32'(x.count));
      check("ras_miss", 32'(ras_miss), 32'(x.miss));
      check("ras_empty", 32'(ras_empty), 32'(x.count == 0));
      check("ras_full", 32'(ras_full), 32'(x.count == DEPTH));
    end
  end

  initial begin
    // Reset, then free-run from RESET_PC.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) idle();

    // Stall holds pco despite a jump; redirect overrides stall.
    redir(32'h200);
    repeat (2) step(0, 0, 0, 0, 1, 32'h400, 1, 0, 0);
    step(0, 0, 1, 32'h800, 0, 0, 0, 0, 0);

    // Simple call/return pair.
    redir(32'h1000);
    do_call(32'h2000);
    repeat (4) idle();
    do_ret(32'hBAD0);

    // Nine nested calls overflow the 8-deep stack, nine returns drain it.
    redir(32'h0);
    for (int i = 1; i <= 9; i++) do_call(32'(i * 16));
    for (int i = 0; i < 9; i++) do_ret(32'hDEAD0);
    idle();

    // Sequential wrap at the top of the address space.
    redir(32'hFFFF_FFFC);
    idle();

    // Return+call in one cycle replaces the top entry, then reset mid-run.
    redir(32'h1000);
    do_call(32'h3000);
    do_call(32'h5000);
    step(0, 1, 0, 0, 1, 32'h7000, 1, 1, 32'hDEAD0);
    step(1, 1, 0, 0, 1, 32'h9000, 1, 0, 0);
    idle();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      logic rst, e, rv, jv, c, rt;
      rst = ($urandom_range(99) == 0);
      e   = ($urandom_range(9) != 0);
      rv  = ($urandom_range(19) == 0);
      jv  = ($urandom_range(2) == 0);
      c   = $urandom_range(1);
      rt  = ($urandom_range(4) == 0);
      step(rst, e, rv, $urandom & 32'hFFFF_FFFC, jv, $urandom & 32'hFFFF_FFFC, c, rt,
           $urandom & 32'hFFFF_FFFC);
    end

    @(negedge CLK);
    RST = 1'b0; en = 1'b0; redirect_valid = 1'b0; jump_valid = 1'b0;
    call = 1'b0; ret_valid = 1'b0;
    for (int t = 0; t < 10 && sb.size() > 0; t++) @(negedge CLK);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
